pwm_capture: RTL and testbench

- Receive-side counterpart of the team's PWM generator: measures high and low durations of an incoming PWM waveform in clk cycles.
- Publishes each complete period as a single-cycle result strobe.
- Used to read back generator outputs, external fan/servo feedback and duty-cycle sensors.
- Flags a dead or stuck line with a timeout.

---
 rtl/pwm_capture.sv | 158 +++++++++++++++
 tb/tb_pwm_capture.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// Measures high/low durations of an asynchronous PWM input in clk cycles and strobes each complete period.
// Optional glitch filter on the synchronized input is enabled with PWM_CAP_FILTER_EN.
module pwm_capture #(
   parameter int WIDTH       = 16,
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pwm_in,
   output logic [WIDTH-1:0] high_time,
   output logic [WIDTH-1:0] low_time,
   output logic [WIDTH:0]   period,
   output logic             valid,
   output logic             timeout
);

   // state     | meaning
   // ARM       | wait for a settled low line before trusting edges
   // WAIT_RISE | line low, waiting for the first rising edge
   // HIGH      | counting high cycles
   // LOW       | counting low cycles; next rise publishes the period
   typedef enum logic [1:0] {ARM, WAIT_RISE, HIGH, LOW} state_t;

   localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

`ifdef PWM_CAP_FILTER_EN
   localparam int PIPE_DEPTH = SYNC_STAGES + FILTER_LEN;
`else
   localparam int PIPE_DEPTH = SYNC_STAGES;
`endif
   localparam int WW = $clog2(PIPE_DEPTH + 1);

   state_t               state, state_nxt;
   logic [SYNC_STAGES-1:0] sync;
   logic                 s_sync, s, s_d, rise, fall;
   logic [WW-1:0]        warm_cnt;
   logic                 warm;
   logic [WIDTH-1:0]     cnt, high_tmp;
   logic                 cnt_ld, cnt_inc, cap_high, publish, sat;

   always_ff @(posedge clk) begin
      if (rst) sync <= '0;
      else     sync <= {sync[SYNC_STAGES-2:0], pwm_in};
   end
   assign s_sync = sync[SYNC_STAGES-1];

`ifdef PWM_CAP_FILTER_EN
   localparam int FW = $clog2(FILTER_LEN + 1);
   logic [FW-1:0] flt_cnt;
   logic          flt;

   always_ff @(posedge clk) begin
      if (rst) begin
         flt_cnt <= '0;
         flt     <= 1'b0;
      end else if (s_sync == flt) begin
         flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
         flt     <= s_sync;
         flt_cnt <= '0;
      end else begin
         flt_cnt <= flt_cnt + 1'b1;
      end
   end
   assign s = flt;
`else
   assign s = s_sync;
`endif

   // Reset zeroes the input pipeline, so s reads low until it refills; ARM must not
   // mistake that for a real low on a line that is actually high.
   always_ff @(posedge clk) begin
      if (rst)        warm_cnt <= '0;
      else if (!warm) warm_cnt <= warm_cnt + 1'b1;
   end
   assign warm = (warm_cnt == WW'(PIPE_DEPTH));

   always_ff @(posedge clk) begin
      if (rst) s_d <= 1'b0;
      else     s_d <= s;
   end
   assign rise = s & ~s_d;
   assign fall = ~s & s_d;

   always_ff @(posedge clk) begin
      if (rst) state <= ARM;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cnt_ld    = 1'b0;
      cnt_inc   = 1'b0;
      cap_high  = 1'b0;
      publish   = 1'b0;
      sat       = 1'b0;
      case (state)
         ARM:       if (warm && !s) state_nxt = WAIT_RISE;
         WAIT_RISE: if (rise) begin
                       cnt_ld    = 1'b1;
                       state_nxt = HIGH;
                    end
         HIGH:      if (fall) begin
                       cap_high  = 1'b1;
                       cnt_ld    = 1'b1;
                       state_nxt = LOW;
                    end else if (s) begin
                       if (cnt == CNT_MAX) begin
                          sat       = 1'b1;
                          state_nxt = ARM;
                       end else begin
                          cnt_inc = 1'b1;
                       end
                    end
         LOW:       if (rise) begin
                       publish   = 1'b1;
                       cnt_ld    = 1'b1;
                       state_nxt = HIGH;
                    end else if (!s) begin
                       if (cnt == CNT_MAX) begin
                          sat       = 1'b1;
                          state_nxt = ARM;
                       end else begin
                          cnt_inc = 1'b1;
                       end
                    end
         default:   state_nxt = ARM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         high_tmp  <= '0;
         high_time <= '0;
         low_time  <= '0;
         period    <= '0;
         valid     <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         valid <= publish;
         if (cnt_ld)       cnt <= {{(WIDTH-1){1'b0}}, 1'b1};
         else if (cnt_inc) cnt <= cnt + 1'b1;
         else if (sat)     cnt <= '0;
         if (cap_high) high_tmp <= cnt;
         if (publish) begin
            high_time <= high_tmp;
            low_time  <= cnt;
            period    <= {1'b0, high_tmp} + {1'b0, cnt};
            timeout   <= 1'b0;
         end else if (sat) begin
            timeout <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: a run-length model of the input predicts each published period.
// Stimulus durations adapt when PWM_CAP_FILTER_EN is defined so no intended edge gets filtered.
module tb_pwm_capture;

   localparam int W    = 8;
   localparam int MAXV = 255;
`ifdef PWM_CAP_FILTER_EN
   localparam int S2 = 4;
   localparam int S3 = 4;
`else
   localparam int S2 = 2;
   localparam int S3 = 3;
`endif
   localparam int S14 = 16 - S2;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         pwm_in = 1'b0;
   logic [W-1:0] high_time, low_time;
   logic [W:0]   period;
   logic         valid, timeout;

   always #5 clk = ~clk;

   pwm_capture #(.WIDTH(W), .SYNC_STAGES(2), .FILTER_LEN(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .pwm_in    (pwm_in),
      .high_time (high_time),
      .low_time  (low_time),
      .period    (period),
      .valid     (valid),
      .timeout   (timeout)
   );

   typedef struct {int h; int l;} meas_t;
   meas_t sbq[$];
   meas_t mon_m;

   int n_chk  = 0;
   int n_pass = 0;

   // model: 0 = armed, 1 = waiting for a high run, 2 = high captured, waiting for low
   int   m_st    = 0;
   int   m_h     = 0;
   int   last_h  = 0;
   int   last_l  = 0;
   int   cur_len = 0;
   logic cur_lvl = 1'b0;
   logic prev_valid = 1'b0;

   task automatic chk(string tag, int got, int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic complete(logic lvl, int len);
      case (m_st)
         0: if (!lvl) m_st = 1;
         1: if (lvl) begin
               if (len > MAXV) m_st = 0;
               else begin
                  m_h  = len;
                  m_st = 2;
               end
            end
         default: if (!lvl) begin
               if (len > MAXV) m_st = 1;
               else begin
                  sbq.push_back('{m_h, len});
                  last_h = m_h;
                  last_l = len;
                  m_st   = 1;
               end
            end
      endcase
   endtask

   task automatic run(logic lvl, int n);
      if (lvl != cur_lvl) begin
         complete(cur_lvl, cur_len);
         cur_lvl = lvl;
         cur_len = 0;
      end
      pwm_in  = lvl;
      cur_len += n;
      repeat (n) @(negedge clk);
   endtask

   // With the filter enabled a short excursion is invisible, so the model keeps counting the current level.
   task automatic glitch(logic lvl, int n);
`ifdef PWM_CAP_FILTER_EN
      pwm_in  = lvl;
      cur_len += n;
      repeat (n) @(negedge clk);
      pwm_in  = cur_lvl;
`else
      run(lvl, n);
`endif
   endtask

   task automatic do_reset(int cyc);
      chk("pre_reset_queue", sbq.size(), 0);
      sbq.delete();
      rst  = 1'b1;
      m_st = 0;
      repeat (cyc) @(negedge clk);
      chk("rst_high_time", high_time, 0);
      chk("rst_low_time",  low_time,  0);
      chk("rst_period",    period,    0);
      chk("rst_valid",     valid,     0);
      chk("rst_timeout",   timeout,   0);
      rst = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (valid) begin
            chk("valid_width", prev_valid, 0);
            if (sbq.size() == 0) begin
               chk("spurious_valid", valid, 0);
            end else begin
               mon_m = sbq.pop_front();
               chk("high_time", high_time, mon_m.h);
               chk("low_time",  low_time,  mon_m.l);
               chk("period",    period,    mon_m.h + mon_m.l);
               chk("valid_timeout", timeout, 0);
            end
         end
         prev_valid = valid;
      end else begin
         prev_valid = 1'b0;
      end
   end

   initial begin
      do_reset(5);

      // steady 3 high / 5 low
      run(0, 10);
      repeat (5) begin
         run(1, S3);
         run(0, 5);
      end
      run(1, S3);

      // line high through reset release
      run(1, 10);
      do_reset(4);
      run(1, 10);
      run(0, 10); run(1, 6); run(0, 10); run(1, 6);

      // stuck high saturates the 8-bit counter
      run(0, 10);
      run(1, 300);
      chk("stuck_timeout",   timeout,   1);
      chk("stuck_high_time", high_time, last_h);
      chk("stuck_low_time",  low_time,  last_l);
      chk("stuck_period",    period,    last_h + last_l);
      run(0, 4); run(1, 4); run(0, 4); run(1, 10);
      chk("timeout_cleared", timeout, 0);

      // duty swap mid-stream
      run(0, S14); run(1, S2); run(0, S14); run(1, S2); run(0, S14);
      run(1, S14); run(0, S2); run(1, S14); run(0, S2);

      // reset pulse in the middle of a high phase
      run(1, 10);
      do_reset(1);
      run(1, 10);
      run(0, 8); run(1, 5); run(0, 7); run(1, 8);

      // 20/20 with short low glitches inside the high phase
      run(0, 20);
      run(1, 9); glitch(0, 2); run(1, 9); run(0, 20);
      run(1, 9); glitch(0, 2); run(1, 9); run(0, 20);
      run(1, 20);
      run(0, 30);

      chk("scoreboard_drained", sbq.size(), 0);
      chk("final_high_time", high_time, last_h);
      chk("final_low_time",  low_time,  last_l);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
